// File: rtl/uart_int_ctrl.sv
// UART interrupt controller: latches line-status, RX-data, RX-timeout, THR-empty
// and modem-status events, prioritises the enabled ones into IIR and the IRQ line.
module uart_int_ctrl #(
    parameter int TO_CHARS = 4,
    parameter int TO_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ier,
    input  logic       fifo_en,
    input  logic       pe,
    input  logic       fe,
    input  logic       bi,
    input  logic       oe,
    input  logic       lsr_read,
    input  logic       rx_empty,
    input  logic       rx_trig,
    input  logic       rx_push,
    input  logic       rx_pop,
    input  logic       char_tick,
    input  logic       thr_empty,
    input  logic       thr_write,
    input  logic       iir_read,
    input  logic       msr_delta,
    input  logic       msr_read,
    output logic [7:0] iir,
    output logic       uart_intpt
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CHARS);

    logic            ls_p_q, ls_p_d;
    logic            rda_p_q, rda_p_d;
    logic            to_p_q, to_p_d;
    logic            thre_p_q, thre_p_d;
    logic            ms_p_q, ms_p_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            thr_empty_hist_q, thr_empty_hist_d;
    logic            etbei_hist_q, etbei_hist_d;
    logic            hist_vld_q, hist_vld_d;

    logic [3:0]      iid;
    logic            to_clr;
    logic            thre_set;
    logic            thre_clr;

    // Interrupt identification: fixed priority over enabled pending flags.
    always_comb begin
        iid = 4'b0001;
        if (ls_p_q && ier[2]) begin
            iid = 4'b0110;
        end else if (rda_p_q && ier[0]) begin
            iid = 4'b0100;
        end else if (to_p_q && ier[0]) begin
            iid = 4'b1100;
        end else if (thre_p_q && ier[1]) begin
            iid = 4'b0010;
        end else if (ms_p_q && ier[3]) begin
            iid = 4'b0000;
        end
    end

    assign iir        = {(fifo_en ? 2'b11 : 2'b00), 2'b00, iid};
    assign uart_intpt = ~iid[0];

    always_comb begin
        ls_p_d = ls_p_q;
        if (pe || fe || bi || oe) begin
            ls_p_d = 1'b1;
        end else if (lsr_read) begin
            ls_p_d = 1'b0;
        end

        rda_p_d = fifo_en ? rx_trig : ~rx_empty;

        to_clr   = rx_pop || rx_empty || !fifo_en;
        to_cnt_d = to_cnt_q;
        if (rx_push || to_clr) begin
            to_cnt_d = '0;
        end else if (char_tick && (to_cnt_q != TO_MAX)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        to_p_d = to_p_q;
        if (to_clr) begin
            to_p_d = 1'b0;
        end else if (to_cnt_q == TO_MAX) begin
            to_p_d = 1'b1;
        end

        // Edge history is only trusted once it has been loaded after reset, so a
        // level already high at reset release is not mistaken for a rising edge.
        thre_set = hist_vld_q &&
                   ((thr_empty && !thr_empty_hist_q) ||
                    (thr_empty && ier[1] && !etbei_hist_q));
        thre_clr = thr_write || (iir_read && (iid == 4'b0010));
        thre_p_d = thre_p_q;
        if (thre_clr) begin
            thre_p_d = 1'b0;
        end else if (thre_set) begin
            thre_p_d = 1'b1;
        end

        ms_p_d = ms_p_q;
        if (msr_delta) begin
            ms_p_d = 1'b1;
        end else if (msr_read) begin
            ms_p_d = 1'b0;
        end

        thr_empty_hist_d = thr_empty;
        etbei_hist_d     = ier[1];
        hist_vld_d       = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ls_p_q           <= 1'b0;
            rda_p_q          <= 1'b0;
            to_p_q           <= 1'b0;
            thre_p_q         <= 1'b0;
            ms_p_q           <= 1'b0;
            to_cnt_q         <= '0;
            thr_empty_hist_q <= 1'b0;
            etbei_hist_q     <= 1'b0;
            hist_vld_q       <= 1'b0;
        end else begin
            ls_p_q           <= ls_p_d;
            rda_p_q          <= rda_p_d;
            to_p_q           <= to_p_d;
            thre_p_q         <= thre_p_d;
            ms_p_q           <= ms_p_d;
            to_cnt_q         <= to_cnt_d;
            thr_empty_hist_q <= thr_empty_hist_d;
            etbei_hist_q     <= etbei_hist_d;
            hist_vld_q       <= hist_vld_d;
        end
    end

endmodule

// File: tb/tb_uart_int_ctrl.sv
// Directed bench for uart_int_ctrl: each task drives one scenario and checks
// iir / uart_intpt against hand-computed values.
module tb_uart_int_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] ier;
    logic       fifo_en;
    logic       pe, fe, bi, oe;
    logic       lsr_read;
    logic       rx_empty, rx_trig, rx_push, rx_pop;
    logic       char_tick;
    logic       thr_empty, thr_write, iir_read;
    logic       msr_delta, msr_read;
    logic [7:0] iir;
    logic       uart_intpt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_int_ctrl #(.TO_CHARS(4), .TO_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .ier        (ier),
        .fifo_en    (fifo_en),
        .pe         (pe),
        .fe         (fe),
        .bi         (bi),
        .oe         (oe),
        .lsr_read   (lsr_read),
        .rx_empty   (rx_empty),
        .rx_trig    (rx_trig),
        .rx_push    (rx_push),
        .rx_pop     (rx_pop),
        .char_tick  (char_tick),
        .thr_empty  (thr_empty),
        .thr_write  (thr_write),
        .iir_read   (iir_read),
        .msr_delta  (msr_delta),
        .msr_read   (msr_read),
        .iir        (iir),
        .uart_intpt (uart_intpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_char();
        char_tick = 1'b1;
        step();
        char_tick = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; ier = 4'b0010; fifo_en = 1'b0; thr_empty = 1'b1; rx_empty = 1'b1;
        step(); step();
        rst = 1'b0;
        total_cnt++;
        if (iir !== 8'h01) $display("FAIL reset_iir got %h exp %h", iir, 8'h01); else pass_cnt++;
        total_cnt++;
        if (uart_intpt !== 1'b0) $display("FAIL reset_intpt got %b exp 0", uart_intpt); else pass_cnt++;
        step();
        total_cnt++;
        if (iir !== 8'h01) $display("FAIL thr_level_at_release_1 got %h exp %h", iir, 8'h01); else pass_cnt++;
        step();
        total_cnt++;
        if (iir !== 8'h01) $display("FAIL thr_level_at_release_2 got %h exp %h", iir, 8'h01); else pass_cnt++;
        fifo_en = 1'b1;
        #1;
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL reset_iir_fifo got %h exp %h", iir, 8'hC1); else pass_cnt++;
        fifo_en = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_thre();
        thr_empty = 1'b0; step();
        thr_empty = 1'b1; step();
        total_cnt++;
        if (iir !== 8'h02) $display("FAIL thre_edge_iir got %h exp %h", iir, 8'h02); else pass_cnt++;
        total_cnt++;
        if (uart_intpt !== 1'b1) $display("FAIL thre_edge_intpt got %b exp 1", uart_intpt); else pass_cnt++;
        iir_read = 1'b1;
        #1;
        total_cnt++;
        if (iir !== 8'h02) $display("FAIL thre_preclear_read got %h exp %h", iir, 8'h02); else pass_cnt++;
        step();
        iir_read = 1'b0;
        total_cnt++;
        if (iir !== 8'h01) $display("FAIL thre_iir_read_clear got %h exp %h", iir, 8'h01); else pass_cnt++;
        ier = 4'b0000; step();
        ier = 4'b0010; step();
        total_cnt++;
        if (iir !== 8'h02) $display("FAIL thre_etbei_edge got %h exp %h", iir, 8'h02); else pass_cnt++;
        thr_write = 1'b1; step(); thr_write = 1'b0;
        total_cnt++;
        if (iir !== 8'h01) $display("FAIL thre_write_clear got %h exp %h", iir, 8'h01); else pass_cnt++;
        $display("test_thre done");
    endtask

    task automatic test_back_to_back();
        thr_empty = 1'b0; step();
        thr_empty = 1'b1; step();
        total_cnt++;
        if (iir !== 8'h02) $display("FAIL b2b_setup got %h exp %h", iir, 8'h02); else pass_cnt++;
        thr_empty = 1'b0; step();
        total_cnt++;
        if (iir !== 8'h02) $display("FAIL b2b_hold got %h exp %h", iir, 8'h02); else pass_cnt++;
        thr_empty = 1'b1; thr_write = 1'b1; step(); thr_write = 1'b0;
        total_cnt++;
        if (iir !== 8'h01) $display("FAIL b2b_clear_wins got %h exp %h", iir, 8'h01); else pass_cnt++;
        step();
        total_cnt++;
        if (iir !== 8'h01) $display("FAIL b2b_after got %h exp %h", iir, 8'h01); else pass_cnt++;
        $display("test_back_to_back done");
    endtask

    task automatic test_ls_rda();
        ier = 4'b0111; rx_empty = 1'b0; step();
        total_cnt++;
        if (iir !== 8'h04) $display("FAIL rda_nonfifo got %h exp %h", iir, 8'h04); else pass_cnt++;
        fe = 1'b1; step(); fe = 1'b0;
        total_cnt++;
        if (iir !== 8'h06) $display("FAIL ls_over_rda got %h exp %h", iir, 8'h06); else pass_cnt++;
        lsr_read = 1'b1; step(); lsr_read = 1'b0;
        total_cnt++;
        if (iir !== 8'h04) $display("FAIL ls_clear got %h exp %h", iir, 8'h04); else pass_cnt++;
        pe = 1'b1; lsr_read = 1'b1; step(); pe = 1'b0; lsr_read = 1'b0;
        total_cnt++;
        if (iir !== 8'h06) $display("FAIL ls_set_wins got %h exp %h", iir, 8'h06); else pass_cnt++;
        lsr_read = 1'b1; step(); lsr_read = 1'b0;
        total_cnt++;
        if (iir !== 8'h04) $display("FAIL ls_clear2 got %h exp %h", iir, 8'h04); else pass_cnt++;
        rx_pop = 1'b1; rx_empty = 1'b1; step(); rx_pop = 1'b0;
        total_cnt++;
        if (iir !== 8'h01) $display("FAIL rda_drained got %h exp %h", iir, 8'h01); else pass_cnt++;
        fifo_en = 1'b1; rx_empty = 1'b0; rx_trig = 1'b1; step();
        total_cnt++;
        if (iir !== 8'hC4) $display("FAIL rda_fifo_trig got %h exp %h", iir, 8'hC4); else pass_cnt++;
        rx_trig = 1'b0; step();
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL rda_fifo_below got %h exp %h", iir, 8'hC1); else pass_cnt++;
        $display("test_ls_rda done");
    endtask

    task automatic test_timeout();
        ier = 4'b0001;
        for (int i = 0; i < 3; i++) tick_char();
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL to_after3 got %h exp %h", iir, 8'hC1); else pass_cnt++;
        char_tick = 1'b1; step(); char_tick = 1'b0;
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL to_reach_cycle got %h exp %h", iir, 8'hC1); else pass_cnt++;
        step();
        total_cnt++;
        if (iir !== 8'hCC) $display("FAIL to_set got %h exp %h", iir, 8'hCC); else pass_cnt++;
        rx_pop = 1'b1; step(); rx_pop = 1'b0;
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL to_pop_clear got %h exp %h", iir, 8'hC1); else pass_cnt++;
        for (int i = 0; i < 3; i++) tick_char();
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL to_restart3 got %h exp %h", iir, 8'hC1); else pass_cnt++;
        tick_char();
        total_cnt++;
        if (iir !== 8'hCC) $display("FAIL to_restart4 got %h exp %h", iir, 8'hCC); else pass_cnt++;
        rx_empty = 1'b1; step();
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL to_empty_clear got %h exp %h", iir, 8'hC1); else pass_cnt++;
        $display("test_timeout done");
    endtask

    task automatic test_masking();
        ier = 4'b0000;
        pe = 1'b1; msr_delta = 1'b1; step(); pe = 1'b0; msr_delta = 1'b0;
        thr_empty = 1'b0; step();
        thr_empty = 1'b1; step();
        total_cnt++;
        if (uart_intpt !== 1'b0) $display("FAIL mask_intpt got %b exp 0", uart_intpt); else pass_cnt++;
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL mask_iir got %h exp %h", iir, 8'hC1); else pass_cnt++;
        ier = 4'hF;
        #1;
        total_cnt++;
        if (uart_intpt !== 1'b1) $display("FAIL unmask_intpt got %b exp 1", uart_intpt); else pass_cnt++;
        total_cnt++;
        if (iir !== 8'hC6) $display("FAIL unmask_iir got %h exp %h", iir, 8'hC6); else pass_cnt++;
        lsr_read = 1'b1; step(); lsr_read = 1'b0;
        total_cnt++;
        if (iir !== 8'hC2) $display("FAIL mask_thre_next got %h exp %h", iir, 8'hC2); else pass_cnt++;
        thr_write = 1'b1; step(); thr_write = 1'b0;
        total_cnt++;
        if (iir !== 8'hC0) $display("FAIL mask_ms_next got %h exp %h", iir, 8'hC0); else pass_cnt++;
        msr_delta = 1'b1; msr_read = 1'b1; step(); msr_delta = 1'b0; msr_read = 1'b0;
        total_cnt++;
        if (iir !== 8'hC0) $display("FAIL ms_set_wins got %h exp %h", iir, 8'hC0); else pass_cnt++;
        msr_read = 1'b1; step(); msr_read = 1'b0;
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL ms_clear got %h exp %h", iir, 8'hC1); else pass_cnt++;
        $display("test_masking done");
    endtask

    task automatic test_reset_mid();
        ier = 4'hF; fifo_en = 1'b1; rx_empty = 1'b0; rx_trig = 1'b0;
        pe = 1'b1; step(); pe = 1'b0;
        for (int i = 0; i < 4; i++) tick_char();
        total_cnt++;
        if (iir !== 8'hC6) $display("FAIL rstmid_pending got %h exp %h", iir, 8'hC6); else pass_cnt++;
        rst = 1'b1; step(); rst = 1'b0;
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL rstmid_after got %h exp %h", iir, 8'hC1); else pass_cnt++;
        total_cnt++;
        if (uart_intpt !== 1'b0) $display("FAIL rstmid_intpt got %b exp 0", uart_intpt); else pass_cnt++;
        step();
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL rstmid_first_cycle got %h exp %h", iir, 8'hC1); else pass_cnt++;
        for (int i = 0; i < 3; i++) tick_char();
        total_cnt++;
        if (iir !== 8'hC1) $display("FAIL rstmid_cnt3 got %h exp %h", iir, 8'hC1); else pass_cnt++;
        tick_char();
        total_cnt++;
        if (iir !== 8'hCC) $display("FAIL rstmid_cnt4 got %h exp %h", iir, 8'hCC); else pass_cnt++;
        $display("test_reset_mid done");
    endtask

    initial begin
        rst = 1'b1; ier = 4'b0000; fifo_en = 1'b0;
        pe = 1'b0; fe = 1'b0; bi = 1'b0; oe = 1'b0; lsr_read = 1'b0;
        rx_empty = 1'b1; rx_trig = 1'b0; rx_push = 1'b0; rx_pop = 1'b0;
        char_tick = 1'b0; thr_empty = 1'b1; thr_write = 1'b0; iir_read = 1'b0;
        msr_delta = 1'b0; msr_read = 1'b0;
        test_reset();
        test_thre();
        test_back_to_back();
        test_ls_rda();
        test_timeout();
        test_masking();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
